approx_pipe_adder: RTL and testbench
====================================

Name: approx_pipe_adder

Overview:
- Parametrised, pipelined approximate adder; successor to the single-mode zero-truncation adder.
- Truncation width K and approximation mode are selectable per transaction at run time.
- Carry chain is split across STAGES register stages, with a valid/ready handshake and backpressure.
- Emits a signed error term (exact minus approximate) per result; sits in the approximate-arithmetic datapath feeding the error-characterisation harness.

Parameters:
- N, 16, operand/sum width; N % STAGES == 0.
- STAGES, 4, pipeline depth; each stage resolves N/STAGES bits of the carry chain.
- KMAX, 8, maximum truncation width; 0 ≤ KMAX < N.

Ports:
- i_Clk  in  1  clock, rising edge.
- i_Rst_n  in  1  asynchronous active-low reset.
- i_Valid  in  1  input operands valid.
- o_Ready  out  1  block accepts input this cycle.
- i_A  in  N  operand A.
- i_B  in  N  operand B.
- i_Mode  in  2  approximation mode: 00 exact, 01 zero-trunc, 10 ones-fill, 11 lower-OR (LOA).
- i_TruncK  in  $clog2(KMAX+1)  truncation width; values > KMAX are clamped to KMAX.
- o_Valid  out  1  result valid.
- i_Ready  in  1  downstream accepts result.
- o_Sum  out  N  approximate sum.
- o_Cout  out  1  carry out of bit N-1 (the real carry, not tied to 0).
- o_Err  out  KMAX+2  signed error: exact (N+1-bit) value minus approximate {Cout,Sum}.

Behaviour:
- Reset (async assert, sync release): all stage valid bits 0; o_Valid=0; o_Sum, o_Cout, o_Err = 0. o_Ready follows the enable rule, so it is 1 during reset.
- Enable: en = !o_Valid || i_Ready. o_Ready = en. The whole pipeline advances only when en=1 (global stall; bubbles are not collapsed).
- Accept: i_Valid && o_Ready. Operands, mode and clamped K are captured into stage 1; mode and K travel with the data.
- Latency: exactly STAGES cycles from accept edge to o_Valid=1 with no stall. Throughput is 1 per cycle.
- While o_Valid && !i_Ready, all outputs hold stable and nothing is accepted.
- Bits [K-1:0], computed in stage 1:
  - 00: bits are exact; the carry into bit K is the real carry. Mode 00 ignores K (K treated as 0).
  - 01: bits = 0; carry into K = 0.
  - 10: bits = all 1; carry into K = 0.
  - 11: bits = A|B; carry into K = A[K-1]&B[K-1] (0 when K=0).
- Bits [N-1:K]: exact ripple with the chosen carry-in. Stage s registers bits [(s+1)·N/STAGES-1 : s·N/STAGES] plus the inter-stage carry. Operand bits not yet consumed are delayed alongside.
- K=0: all modes equal an exact add, and o_Err=0.
- Error, computed in stage 1 from the low part only, then delayed: Err = (A[K-1:0]+B[K-1:0]) − (approxLow + cin·2^K). |Err| < 2^(K+1), so KMAX+2 bits suffice.
- Wrap-around: o_Sum is modulo 2^N; overflow is reported only via o_Cout.
- Reset mid-operation: in-flight transactions are discarded and none emerge after release.
- Simultaneous accept and emit under en=1 is legal every cycle.

Decomposition:
- Shared package approx_pkg:
  - mode enum (MODE_EXACT, MODE_ZERO, MODE_ONES, MODE_LOA).
  - localparam function for the clamped K width.
- Natural sub-module: approx_low_part. Combinational; takes A/B low bits, mode and K; returns the low bits, the carry into K and Err.
- Stage registers, carry ripple slices and the handshake stay in the top module in a generate loop.

Test Plan (N=16, STAGES=4, KMAX=8):
- Mode 00, A=0xFFFF, B=0x0001 → o_Valid 4 cycles after accept; Sum=0x0000, Cout=1, Err=0.
- Mode 01, K=4, A=0x00FF, B=0x0001 → Sum=0x00F0, Cout=0, Err=+16.
- Mode 10, K=4, A=0x00FF, B=0x0001 → Sum=0x00FF, Err=+1. Mode 11, K=4, A=0x000F, B=0x0009 → Sum=0x001F, Err=−7.
- Stream 8 back-to-back random transactions with mixed modes; drop i_Ready for 3 cycles mid-stream → o_Ready=0 and outputs stable during the stall; all 8 results in order and matching the reference model; no loss or duplication.
- i_TruncK=12, mode 01, A=0x0FFF, B=0x0001 → behaves as K=8: Sum=0x0F00, Err=+256.
- Assert i_Rst_n low with 3 transactions in flight → o_Valid=0 and outputs 0 immediately; no stale result after release; first new accept emerges after exactly 4 cycles.

Source files
------------

// File: rtl/approx_pipe_adder_pkg.sv
// Shared types for the approximate pipelined adder: the per-transaction
// approximation mode and the width of the truncation-width field.
package approx_pkg;

   typedef enum logic [1:0] {
      MODE_EXACT = 2'b00,
      MODE_ZERO  = 2'b01,
      MODE_ONES  = 2'b10,
      MODE_LOA   = 2'b11
   } approx_mode_e;

   // Width of the K field able to hold 0..kmax; never narrower than 1 bit.
   function automatic int k_width(input int kmax);
      return (kmax < 1) ? 1 : $clog2(kmax + 1);
   endfunction

endpackage

// File: rtl/approx_pipe_adder_low_part.sv
// Combinational low-part generator: approximate bits [K-1:0], the carry
// injected into bit K, and the signed error against the exact low sum.
module approx_low_part
   import approx_pkg::*;
#(
   parameter int KMAX = 8,
   parameter int KW   = k_width(KMAX)
) (
   input  logic [KMAX-1:0]       a,
   input  logic [KMAX-1:0]       b,
   input  approx_mode_e          mode,
   input  logic [KW-1:0]         k,
   output logic [KMAX-1:0]       low,
   output logic [KMAX-1:0]       mask,
   output logic [KMAX-1:0]       inj,
   output logic signed [KMAX+1:0] err
);

   logic [KW-1:0]   ke;
   logic [KMAX-1:0] top;
   logic            cin;
   logic [KMAX:0]   exact_lo;
   logic [KMAX:0]   approx_lo;

   always_comb begin
      ke = (mode == MODE_EXACT) ? '0 : k;
      for (int i = 0; i < KMAX; i++) begin
         mask[i] = (i < int'(ke));
      end
      // one-hot marker on bit K-1, where the injected carry lives
      top = mask & ~(mask >> 1);
      low = '0;
      cin = 1'b0;
      case (mode)
         MODE_ONES: low = mask;
         MODE_LOA: begin
            low = (a | b) & mask;
            cin = |(a & b & top);
         end
         default: low = '0;
      endcase
      inj       = top & {KMAX{cin}};
      exact_lo  = {1'b0, a & mask} + {1'b0, b & mask};
      approx_lo = {1'b0, low} + ({{KMAX{1'b0}}, cin} << ke);
      err       = signed'({1'b0, exact_lo}) - signed'({1'b0, approx_lo});
   end

endmodule

// File: rtl/approx_pipe_adder.sv
// Pipelined approximate adder: low part resolved on entry, upper carry chain
// rippled one N/STAGES slice per stage, global-stall valid/ready handshake.
module approx_pipe_adder
   import approx_pkg::*;
#(
   parameter  int N      = 16,
   parameter  int STAGES = 4,
   parameter  int KMAX   = 8,
   localparam int KW     = k_width(KMAX)
) (
   input  logic                   i_Clk,
   input  logic                   i_Rst_n,
   input  logic                   i_Valid,
   output logic                   o_Ready,
   input  logic [N-1:0]           i_A,
   input  logic [N-1:0]           i_B,
   input  logic [1:0]             i_Mode,
   input  logic [KW-1:0]          i_TruncK,
   output logic                   o_Valid,
   input  logic                   i_Ready,
   output logic [N-1:0]           o_Sum,
   output logic                   o_Cout,
   output logic signed [KMAX+1:0] o_Err
);

   localparam int W = N / STAGES;

   logic                   en;
   logic [STAGES:1]        vld_pipe;
   logic [KW-1:0]          k_c;
   logic [KMAX-1:0]        low_lo, mask_lo, inj_lo;
   logic signed [KMAX+1:0] err_lo;

   assign en      = !o_Valid || i_Ready;
   assign o_Ready = en;
   assign k_c     = (i_TruncK > KW'(KMAX)) ? KW'(KMAX) : i_TruncK;

   approx_low_part #(.KMAX(KMAX), .KW(KW)) u_low (
      .a    (i_A[KMAX-1:0]),
      .b    (i_B[KMAX-1:0]),
      .mode (approx_mode_e'(i_Mode)),
      .k    (k_c),
      .low  (low_lo),
      .mask (mask_lo),
      .inj  (inj_lo),
      .err  (err_lo)
   );

   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         vld_pipe <= '0;
      end else if (en) begin
         vld_pipe[1] <= i_Valid;
         for (int s = 2; s <= STAGES; s++) vld_pipe[s] <= vld_pipe[s-1];
      end
   end

   // Stage s consumes operand bits from s*W upward; *_d vectors are rebased
   // so bit 0 is bit s*W of the original operands.
   for (genvar s = 0; s < STAGES; s++) begin : g_st
      localparam int RIN = N - s * W;

      logic [RIN-1:0]         a_d, b_d, mask_d, low_d, inj_d;
      logic                   c_d, c_n, c_q;
      logic signed [KMAX+1:0] err_d, err_q;
      logic [W-1:0]           slice;
      logic [(s+1)*W-1:0]     sum_d, sum_q;

      if (s == 0) begin : g_src
         assign a_d    = i_A;
         assign b_d    = i_B;
         assign mask_d = {{(N-KMAX){1'b0}}, mask_lo};
         assign low_d  = {{(N-KMAX){1'b0}}, low_lo};
         assign inj_d  = {{(N-KMAX){1'b0}}, inj_lo};
         assign c_d    = 1'b0;
         assign err_d  = err_lo;
         assign sum_d  = slice;
      end else begin : g_src
         assign a_d    = g_st[s-1].g_fwd.a_q;
         assign b_d    = g_st[s-1].g_fwd.b_q;
         assign mask_d = g_st[s-1].g_fwd.mask_q;
         assign low_d  = g_st[s-1].g_fwd.low_q;
         assign inj_d  = g_st[s-1].g_fwd.inj_q;
         assign c_d    = g_st[s-1].c_q;
         assign err_d  = g_st[s-1].err_q;
         assign sum_d  = {slice, g_st[s-1].sum_q};
      end

      // Masked bits take the approximate value and hand over the injected carry.
      always_comb begin
         slice = '0;
         c_n   = c_d;
         for (int j = 0; j < W; j++) begin
            if (mask_d[j]) begin
               slice[j] = low_d[j];
               c_n      = inj_d[j];
            end else begin
               slice[j] = a_d[j] ^ b_d[j] ^ c_n;
               c_n      = (a_d[j] & b_d[j]) | (c_n & (a_d[j] ^ b_d[j]));
            end
         end
      end

      always_ff @(posedge i_Clk or negedge i_Rst_n) begin
         if (!i_Rst_n) begin
            sum_q <= '0;
            c_q   <= 1'b0;
            err_q <= '0;
         end else if (en) begin
            sum_q <= sum_d;
            c_q   <= c_n;
            err_q <= err_d;
         end
      end

      if (s < STAGES - 1) begin : g_fwd
         logic [RIN-W-1:0] a_q, b_q, mask_q, low_q, inj_q;

         always_ff @(posedge i_Clk or negedge i_Rst_n) begin
            if (!i_Rst_n) begin
               a_q    <= '0;
               b_q    <= '0;
               mask_q <= '0;
               low_q  <= '0;
               inj_q  <= '0;
            end else if (en) begin
               a_q    <= a_d[RIN-1:W];
               b_q    <= b_d[RIN-1:W];
               mask_q <= mask_d[RIN-1:W];
               low_q  <= low_d[RIN-1:W];
               inj_q  <= inj_d[RIN-1:W];
            end
         end
      end
   end

   assign o_Valid = vld_pipe[STAGES];
   assign o_Sum   = g_st[STAGES-1].sum_q;
   assign o_Cout  = g_st[STAGES-1].c_q;
   assign o_Err   = g_st[STAGES-1].err_q;

endmodule

// File: tb/tb_approx_pipe_adder.sv
// Bench for approx_pipe_adder: directed vector table, random stream with a
// downstream stall, latency and mid-flight reset sequences; queue scoreboard.
module tb_approx_pipe_adder;

   logic              i_Clk = 1'b0;
   logic              i_Rst_n, i_Valid, i_Ready, o_Ready, o_Valid, o_Cout;
   logic [15:0]       i_A, i_B, o_Sum;
   logic [1:0]        i_Mode;
   logic [3:0]        i_TruncK;
   logic signed [9:0] o_Err;

   approx_pipe_adder #(.N(16), .STAGES(4), .KMAX(8)) dut (
      .i_Clk(i_Clk), .i_Rst_n(i_Rst_n), .i_Valid(i_Valid), .o_Ready(o_Ready),
      .i_A(i_A), .i_B(i_B), .i_Mode(i_Mode), .i_TruncK(i_TruncK),
      .o_Valid(o_Valid), .i_Ready(i_Ready), .o_Sum(o_Sum), .o_Cout(o_Cout),
      .o_Err(o_Err)
   );

   always #5 i_Clk = ~i_Clk;

   typedef struct {
      logic [15:0] sum;
      logic        cout;
      int          err;
   } exp_t;

   typedef struct {
      logic [15:0] a, b;
      logic [1:0]  mode;
      logic [3:0]  k;
      logic [15:0] sum;
      logic        cout;
      int          err;
   } vec_t;

   exp_t sb[$];
   int   checks = 0, errors = 0;
   int   stalls_seen = 0, emitted = 0;

   task automatic chk(input string name, input longint act, input longint req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   // Arithmetic reference: approximate low field plus an exact upper add.
   function automatic exp_t model(input logic [15:0] a, b, input logic [1:0] mode,
                                  input logic [3:0] k);
      int kk, m, lo, c, hi, full, ai, bi;
      exp_t e;
      ai = a; bi = b;
      kk = (k > 8) ? 8 : int'(k);
      if (mode == 2'd0) kk = 0;
      m = (1 << kk) - 1; lo = 0; c = 0;
      case (mode)
         2'd2: lo = m;
         2'd3: begin
            lo = (ai | bi) & m;
            if (kk > 0) c = ((ai & bi) >> (kk - 1)) & 1;
         end
         default: lo = 0;
      endcase
      hi     = (ai >> kk) + (bi >> kk) + c;
      full   = (hi << kk) | lo;
      e.sum  = full[15:0];
      e.cout = full[16];
      e.err  = ((ai & m) + (bi & m)) - (lo + (c << kk));
      return e;
   endfunction

   // Monitor: pops the scoreboard on every emit, checks hold-stability on stalls.
   initial begin
      logic        hold;
      logic [15:0] p_sum;
      logic        p_cout;
      int          p_err;
      exp_t        e;
      hold = 1'b0; p_sum = '0; p_cout = 1'b0; p_err = 0;
      forever begin
         @(negedge i_Clk);
         if (!i_Rst_n) begin
            hold = 1'b0;
         end else begin
            if (hold) begin
               chk("hold_valid", o_Valid, 1);
               chk("hold_sum", o_Sum, p_sum);
               chk("hold_cout", o_Cout, p_cout);
               chk("hold_err", int'(o_Err), p_err);
            end
            if (o_Valid && !i_Ready) begin
               stalls_seen++;
               chk("stall_ready", o_Ready, 0);
            end
            if (o_Valid && i_Ready) begin
               emitted++;
               if (sb.size() == 0) begin
                  chk("unexpected_result", 1, 0);
               end else begin
                  e = sb.pop_front();
                  chk("sum", o_Sum, e.sum);
                  chk("cout", o_Cout, e.cout);
                  chk("err", int'(o_Err), e.err);
               end
            end
            hold = o_Valid && !i_Ready;
            p_sum = o_Sum; p_cout = o_Cout; p_err = int'(o_Err);
         end
      end
   end

   task automatic send(input logic [15:0] a, b, input logic [1:0] mode,
                       input logic [3:0] k, input exp_t e);
      int n;
      i_A = a; i_B = b; i_Mode = mode; i_TruncK = k; i_Valid = 1'b1;
      n = 0;
      forever begin
         @(negedge i_Clk);
         if (o_Ready) break;
         n++;
         if (n > 100) begin
            chk("accept_timeout", n, 0);
            break;
         end
      end
      if (o_Ready) sb.push_back(e);
      @(posedge i_Clk); #1;
      i_Valid = 1'b0;
   endtask

   task automatic latency_tx(input logic [15:0] a, b, input logic [1:0] mode,
                             input logic [3:0] k, input exp_t e);
      int lat;
      i_A = a; i_B = b; i_Mode = mode; i_TruncK = k; i_Valid = 1'b1;
      @(negedge i_Clk);
      chk("lat_ready", o_Ready, 1);
      sb.push_back(e);
      @(posedge i_Clk); #1;
      i_Valid = 1'b0;
      lat = 0;
      do begin
         @(negedge i_Clk);
         lat++;
      end while (!o_Valid && lat < 20);
      chk("latency", lat, 4);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() > 0 && n < 200) begin
         @(negedge i_Clk);
         n++;
      end
      chk("drain", sb.size(), 0);
      @(posedge i_Clk); #1;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_valid"}, o_Valid, 0);
      chk({tag, "_sum"}, o_Sum, 0);
      chk({tag, "_cout"}, o_Cout, 0);
      chk({tag, "_err"}, int'(o_Err), 0);
      chk({tag, "_ready"}, o_Ready, 1);
   endtask

   initial begin
      vec_t vecs[9];
      exp_t e;
      int   st0, em0;

      vecs[0] = '{16'hFFFF, 16'h0001, 2'd0, 4'd5,  16'h0000, 1'b1, 0};
      vecs[1] = '{16'h00FF, 16'h0001, 2'd1, 4'd4,  16'h00F0, 1'b0, 16};
      vecs[2] = '{16'h00FF, 16'h0001, 2'd2, 4'd4,  16'h00FF, 1'b0, 1};
      vecs[3] = '{16'h000F, 16'h0009, 2'd3, 4'd4,  16'h001F, 1'b0, -7};
      vecs[4] = '{16'h0FFF, 16'h0001, 2'd1, 4'd12, 16'h0F00, 1'b0, 256};
      vecs[5] = '{16'h1234, 16'h4321, 2'd3, 4'd0,  16'h5555, 1'b0, 0};
      vecs[6] = '{16'hFFFF, 16'hFFFF, 2'd2, 4'd8,  16'hFEFF, 1'b1, 255};
      vecs[7] = '{16'h80FF, 16'h80FF, 2'd3, 4'd8,  16'h01FF, 1'b1, -1};
      vecs[8] = '{16'h0001, 16'h0001, 2'd1, 4'd1,  16'h0000, 1'b0, 2};

      i_Rst_n = 1'b0; i_Valid = 1'b0; i_Ready = 1'b1;
      i_A = '0; i_B = '0; i_Mode = '0; i_TruncK = '0;
      #12;
      chk_reset_outputs("reset");
      @(posedge i_Clk); #1;
      i_Rst_n = 1'b1;

      // latency of a single exact-mode overflow add
      e.sum = 16'h0000; e.cout = 1'b1; e.err = 0;
      latency_tx(16'hFFFF, 16'h0001, 2'd0, 4'd0, e);
      drain();

      // directed table, back-to-back
      for (int i = 0; i < 9; i++) begin
         e.sum = vecs[i].sum; e.cout = vecs[i].cout; e.err = vecs[i].err;
         send(vecs[i].a, vecs[i].b, vecs[i].mode, vecs[i].k, e);
      end
      drain();

      // random stream with a 3-cycle downstream stall in the middle
      st0 = stalls_seen; em0 = emitted;
      fork
         begin
            for (int i = 0; i < 8; i++) begin
               logic [15:0] ra, rb;
               logic [1:0]  rm;
               logic [3:0]  rk;
               ra = 16'($urandom); rb = 16'($urandom);
               rm = 2'($urandom_range(0, 3)); rk = 4'($urandom_range(0, 15));
               send(ra, rb, rm, rk, model(ra, rb, rm, rk));
            end
         end
         begin
            repeat (6) @(posedge i_Clk);
            #1 i_Ready = 1'b0;
            repeat (3) @(posedge i_Clk);
            #1 i_Ready = 1'b1;
         end
      join
      drain();
      chk("stall_cycles", stalls_seen - st0, 3);
      chk("stream_count", emitted - em0, 8);

      // reset with three transactions in flight
      for (int i = 0; i < 3; i++) begin
         send(16'(i * 16'h1111), 16'h0F0F, 2'(i), 4'd4,
              model(16'(i * 16'h1111), 16'h0F0F, 2'(i), 4'd4));
      end
      i_Rst_n = 1'b0;
      #1;
      chk_reset_outputs("midreset");
      sb.delete();
      repeat (2) @(posedge i_Clk);
      #1 i_Rst_n = 1'b1;
      em0 = emitted;
      repeat (8) @(posedge i_Clk);
      #1;
      chk("no_stale", emitted - em0, 0);
      latency_tx(16'h00FF, 16'h0001, 2'd1, 4'd4, model(16'h00FF, 16'h0001, 2'd1, 4'd4));
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
